// File: rtl/mem_responder.sv
// Level-request/finish memory responder: accepts one read or write at a time,
// waits LATENCY cycles, then completes with fin held until the request drops.
module mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_fin,
    output logic [31:0] rd_data,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_fin,
    output logic        err,
    output logic        busy
);

    // state | meaning
    // IDLE  | no transaction, waiting for rd_req / wr_req (read has priority)
    // WAIT  | transaction accepted, latency counter running down
    // DONE  | fin (and err / rd_data) held until the matching req drops

    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
    localparam logic [3:0]  LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    state_t      state;
    op_t         op;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] mem [DEPTH];

    logic [32:0]      offset;
    logic             addr_ok;
    logic [IDX_W-1:0] idx;
    logic             mem_we;

    // 33-bit subtraction: a borrow makes offset exceed LIMIT, covering addr < BASE_ADDR
    assign offset  = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign addr_ok = (addr_q[1:0] == 2'b00) && (offset < LIMIT);
    assign idx     = offset[IDX_W+1:2];
    assign mem_we  = !reset && (state == WAIT) && (count == 4'd0) &&
                     (op == OP_WRITE) && addr_ok;

    // Storage is never reset, so it lives outside the async-reset block.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op      <= OP_READ;
            count   <= 4'd0;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            rd_fin  <= 1'b0;
            wr_fin  <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rd_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        addr_q <= rd_addr;
                        op     <= OP_READ;
                        count  <= LAT4;
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end else if (wr_req) begin
                        addr_q <= wr_addr;
                        data_q <= wr_data;
                        op     <= OP_WRITE;
                        count  <= LAT4;
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state <= DONE;
                        err   <= !addr_ok;
                        if (op == OP_READ) begin
                            rd_fin  <= 1'b1;
                            rd_data <= addr_ok ? mem[idx] : 32'h0;
                        end else begin
                            wr_fin <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if ((op == OP_READ && !rd_req) || (op == OP_WRITE && !wr_req)) begin
                        rd_fin <= 1'b0;
                        wr_fin <= 1'b0;
                        err    <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 instance for the main flows,
// a LATENCY=0 instance for the minimum-latency timing.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic        rd_fin, wr_fin, err, busy;
    logic [31:0] rd_data;

    logic        rd_req0 = 1'b0, wr_req0 = 1'b0;
    logic [31:0] rd_addr0 = '0, wr_addr0 = '0, wr_data0 = '0;
    logic        rd_fin0, wr_fin0, err0, busy0;
    logic [31:0] rd_data0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        bit          err;
        int          fin_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [1024];
    bit          rd_prev = 1'b0, wr_prev = 1'b0;

    mem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_fin(rd_fin), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fin(wr_fin),
        .err(err), .busy(busy)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(reset),
        .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_fin(rd_fin0), .rd_data(rd_data0),
        .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_fin(wr_fin0),
        .err(err0), .busy(busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'd4096);
    endfunction

    // Completion monitor: each rising fin pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rd_fin || wr_fin) chk_val("fin_excl", {31'h0, rd_fin & wr_fin}, 32'h0);
        if ((rd_fin && !rd_prev) || (wr_fin && !wr_prev)) begin
            if (sb.size() == 0) begin
                chk_val("sb_unexpected_fin", 32'(sb.size()), 32'h1);
            end else begin
                e = sb.pop_front();
                chk_val("fin_kind", {31'h0, rd_fin}, {31'h0, e.is_rd});
                if (e.is_rd) chk_val("rd_data", rd_data, e.data);
                chk_val("err", {31'h0, err}, {31'h0, e.err});
                if (e.fin_cyc >= 0) chk_val("fin_cycle", 32'(cyc), 32'(e.fin_cyc));
            end
        end
        rd_prev = rd_fin;
        wr_prev = wr_fin;
    end

    task automatic wait_rd_fin(input string tag);
        int n = 0;
        while (!rd_fin && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk_val(tag, {31'h0, rd_fin}, 32'h1);
    endtask

    task automatic wait_wr_fin(input string tag);
        int n = 0;
        while (!wr_fin && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk_val(tag, {31'h0, wr_fin}, 32'h1);
    endtask

    task automatic rd_txn(input logic [31:0] a, input int hold, input bit drop_early);
        logic [31:0] ed, held;
        bit          ee;
        ee = !addr_ok(a);
        ed = ee ? 32'h0 : ref_mem[a[11:2]];
        @(negedge clk);
        rd_addr = a;
        rd_req  = 1'b1;
        sb.push_back('{is_rd: 1'b1, data: ed, err: ee, fin_cyc: cyc + 4});
        @(negedge clk);
        if (drop_early) rd_req = 1'b0;
        rd_addr = a ^ 32'h0000_0004;
        wait_rd_fin("rd_timeout");
        held = rd_data;
        if (drop_early) begin
            @(negedge clk);
            chk_val("rd_pulse", {31'h0, rd_fin}, 32'h0);
        end else begin
            repeat (hold) begin
                @(negedge clk);
                chk_val("rd_fin_hold", {31'h0, rd_fin}, 32'h1);
                chk_val("rd_data_hold", rd_data, ed);
                chk_val("busy_hold", {31'h0, busy}, 32'h1);
            end
            rd_req = 1'b0;
            @(negedge clk);
            chk_val("rd_fin_drop", {31'h0, rd_fin}, 32'h0);
        end
        chk_val("rd_busy_idle", {31'h0, busy}, 32'h0);
        chk_val("rd_data_keep", rd_data, held);
    endtask

    task automatic wr_txn(input logic [31:0] a, input logic [31:0] d);
        bit ee;
        ee = !addr_ok(a);
        @(negedge clk);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        sb.push_back('{is_rd: 1'b0, data: 32'h0, err: ee, fin_cyc: cyc + 4});
        @(negedge clk);
        wr_addr = a + 32'd4;
        wr_data = ~d;
        wait_wr_fin("wr_timeout");
        wr_req = 1'b0;
        @(negedge clk);
        chk_val("wr_fin_drop", {31'h0, wr_fin}, 32'h0);
        chk_val("wr_busy_idle", {31'h0, busy}, 32'h0);
        if (!ee) ref_mem[a[11:2]] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [31:0] a, d;

        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk_val("rst_rd_fin", {31'h0, rd_fin}, 32'h0);
        chk_val("rst_wr_fin", {31'h0, wr_fin}, 32'h0);
        chk_val("rst_err", {31'h0, err}, 32'h0);
        chk_val("rst_busy", {31'h0, busy}, 32'h0);
        chk_val("rst_rd_data", rd_data, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        wr_txn(32'h10, 32'h1234_5678);
        rd_txn(32'h10, 0, 1'b0);

        rd_txn(32'h2, 0, 1'b0);
        rd_txn(32'h1000, 0, 1'b0);
        wr_txn(32'h1000, 32'hDEAD_BEEF);
        wr_txn(32'h11, 32'hDEAD_BEEF);
        rd_txn(32'h10, 0, 1'b0);

        // Simultaneous requests: read served first with the old value.
        wr_txn(32'h20, 32'h0BAD_F00D);
        @(negedge clk);
        c       = cyc;
        rd_addr = 32'h20;
        wr_addr = 32'h20;
        wr_data = 32'hA5A5_A5A5;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        sb.push_back('{is_rd: 1'b1, data: 32'h0BAD_F00D, err: 1'b0, fin_cyc: c + 4});
        sb.push_back('{is_rd: 1'b0, data: 32'h0, err: 1'b0, fin_cyc: c + 9});
        wait_rd_fin("both_rd_timeout");
        rd_req = 1'b0;
        wait_wr_fin("both_wr_timeout");
        wr_req = 1'b0;
        @(negedge clk);
        chk_val("both_busy_idle", {31'h0, busy}, 32'h0);
        ref_mem[8] = 32'hA5A5_A5A5;
        rd_txn(32'h20, 0, 1'b0);

        rd_txn(32'h10, 5, 1'b0);
        rd_txn(32'h20, 0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            a = {20'h0, 10'($urandom_range(64, 1023)), 2'b00};
            d = $urandom;
            wr_txn(a, d);
            rd_txn(a, i, 1'b0);
        end

        // Reset during WAIT of a write must leave memory untouched.
        wr_txn(32'h40, 32'h1111_1111);
        rd_txn(32'h10, 0, 1'b0);
        @(negedge clk);
        wr_addr = 32'h40;
        wr_data = 32'hFFFF_FFFF;
        wr_req  = 1'b1;
        repeat (2) @(negedge clk);
        chk_val("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk_val("mid_rst_rd_fin", {31'h0, rd_fin}, 32'h0);
        chk_val("mid_rst_wr_fin", {31'h0, wr_fin}, 32'h0);
        chk_val("mid_rst_err", {31'h0, err}, 32'h0);
        chk_val("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk_val("mid_rst_rd_data", rd_data, 32'h0);
        wr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rd_txn(32'h40, 0, 1'b0);

        // LATENCY=0: fin high after edge N+1 for acceptance at edge N.
        @(negedge clk);
        rd_addr0 = 32'h3;
        rd_req0  = 1'b1;
        @(negedge clk);
        chk_val("lat0_not_yet", {31'h0, rd_fin0}, 32'h0);
        @(negedge clk);
        chk_val("lat0_fin", {31'h0, rd_fin0}, 32'h1);
        chk_val("lat0_err", {31'h0, err0}, 32'h1);
        chk_val("lat0_data", rd_data0, 32'h0);
        rd_req0 = 1'b0;
        @(negedge clk);
        chk_val("lat0_drop", {31'h0, rd_fin0}, 32'h0);
        chk_val("lat0_busy", {31'h0, busy0}, 32'h0);

        repeat (2) @(negedge clk);
        chk_val("sb_left", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
